encode_m2: RTL and testbench
============================

# encode_m2

Serial M2-line transmitter, the upstream counterpart of the M2 receive decoder. It accepts a 16-bit word through a valid/ready handshake and drives one single-wire frame on `m2_udo`. The frame is a 3-bit high sync header, then 16 data bits and 1 parity bit, all bi-phase encoded as 34 line bits. After the frame the line is held low for an idle gap. Each line bit is held for a fixed number of `clock_system` cycles.

## Interface
- `BIT_CYCLES`, default 288: clock cycles per line bit (83.33 kbit/s at 24 MHz); legal range 16..511.
- `GAP_BITS`, default 4: line-bit periods of forced low after each frame; minimum 2.
- `PARITY_ODD`, default 0: 0 = even parity over `tx_data`, 1 = odd parity.
- `clock_system`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_data`  in  16  word to send, MSB first; sampled only on handshake.
- `tx_valid`  in  1  word available.
- `tx_ready`  out  1  block idle and able to accept a word.
- `m2_udo`  out  1  registered serial line output; idles low.
- `frame_done`  out  1  one-cycle pulse at the end of the gap after each frame.

## Operation
- States: IDLE, HEAD, DATA, GAP. Internal counters:
  - 9-bit bit-period counter `bit_cnt`, running 0..BIT_CYCLES-1.
  - 6-bit line-bit counter `line_cnt`.
  - 34-bit shift register `shreg`.
- IDLE:
  - `tx_ready`=1 and `m2_udo`=0.
  - On `tx_valid`&&`tx_ready`, load `shreg`, clear both counters and go to HEAD.
- Load encoding:
  - Each data bit d[15]..d[0] becomes the pair {d, ~d]: 1 → "10", 0 → "01".
  - Parity bit p = ^tx_data ^ PARITY_ODD, appended as the pair {p, ~p}.
  - `shreg[33:32]` = pair for d[15], …, `shreg[3:2]` = pair for d[0], `shreg[1:0]` = parity pair.
- HEAD:
  - `m2_udo`=1 for 3 line-bit periods.
  - `line_cnt` counts 0..2; on the last cycle of bit 2, clear `line_cnt` and go to DATA.
- DATA:
  - `m2_udo`=`shreg[33]`.
  - At the end of each bit period, shift left by one.
  - After 34 periods, go to GAP.
- GAP:
  - `m2_udo`=0 for GAP_BITS periods.
  - On the last cycle, assert `frame_done` and go to IDLE.
- `tx_ready`=0 in HEAD, DATA and GAP. `tx_valid` is ignored outside IDLE. `tx_data` may change freely after acceptance.
- Bit-period end is `bit_cnt`==BIT_CYCLES-1; the counter wraps to 0 on the next cycle.
- Sync header plus a low gap of at least 2 periods guarantees that the decoder sees a fresh rising edge for every frame.

## Timing
- Reset values:
  - `m2_udo`=0, `tx_ready`=1, `frame_done`=0.
  - State IDLE, counters 0, `shreg` 0.
- Reset asserted mid-frame:
  - Line drops to 0 asynchronously and the frame is abandoned.
  - After release the block is in IDLE with `tx_ready`=1.
  - No `frame_done` pulse for the aborted frame.
- Handshake accepted on the rising edge at cycle N:
  - `tx_ready`=0 from cycle N+1.
  - `m2_udo` rises at cycle N+1 (registered output, 1-cycle latency).
- Line bit k of the frame (k=0..36, counting the 3 header bits first) occupies cycles N+1+k·BIT_CYCLES through N+(k+1)·BIT_CYCLES.
- GAP spans GAP_BITS·BIT_CYCLES cycles.
  - `frame_done`=1 during exactly one cycle, the last cycle of GAP.
  - `tx_ready` returns to 1 in the following cycle.
- Frame period, accept to next possible accept: (37+GAP_BITS)·BIT_CYCLES+1 cycles; 11,809 with defaults.
- `tx_valid` held high continuously produces back-to-back frames separated by exactly the gap.

## Test plan
- Reset behaviour:
  - Stimulus: hold `rst`=1 for 10 cycles, release, keep `tx_valid`=0.
  - Required: `m2_udo`=0, `tx_ready`=1 and `frame_done`=0 for 20,000 cycles.
- Single frame, 16'hA5C3, defaults:
  - Required line pattern: 111, then 10 01 10 01 01 10 01 10 10 10 01 01 01 01 10 10, then parity pair 01.
  - Each line bit lasts 288 cycles, then 1152 cycles low.
  - `frame_done` asserts 11,808 cycles after the accept edge.
- Parity and all-ones, 16'hFFFF:
  - PARITY_ODD=0 gives trailer 01; PARITY_ODD=1 gives trailer 10.
  - 16'h0000 with even parity gives 32 line bits alternating 01 and trailer 01.
- Back-to-back traffic:
  - Stimulus: `tx_valid` held high with 16'h1234 then 16'h8001.
  - Required: exactly two frames, `tx_ready` low throughout each frame, gap exactly 1152 cycles low, second word sent unaltered.
- Reset mid-DATA:
  - Stimulus: assert `rst` at line bit 20.
  - Required: `m2_udo`=0 within the same cycle, no `frame_done`, and a clean full frame on the next accept.
- Loopback:
  - Stimulus: connect `m2_udo` to the M2 receive decoder and send 100 random words.
  - Required: every decoded word equals the sent word, with one read pulse per frame.

Source files
------------

// File: rtl/encode_m2.sv
// encode_m2 : serial M2-line transmitter.
//
// Accepts a 16-bit word on a valid/ready handshake and sends one frame on a
// single wire: 3 high sync bits, then 16 data bits MSB first and one parity
// bit, each bi-phase encoded as a pair {b, ~b} (34 line bits). A forced-low
// gap of GAP_BITS line-bit periods follows every frame. Each line bit lasts
// BIT_CYCLES clock cycles.
//
// Parameters:
//   BIT_CYCLES  clock cycles per line bit (16..511)
//   GAP_BITS    line-bit periods of low gap after a frame (>= 2)
//   PARITY_ODD  0 = even parity over tx_data, 1 = odd parity
//
// Ports:
//   clock_system  in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   tx_data       in   word to send, sampled only on handshake
//   tx_valid      in   word available
//   tx_ready      out  idle and able to accept a word
//   m2_udo        out  registered serial line, idles low
//   frame_done    out  one-cycle pulse in the last cycle of the gap
module encode_m2 #(
  parameter int BIT_CYCLES = 288,
  parameter int GAP_BITS   = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic        clock_system,
  input  logic        rst,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        m2_udo,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, HEAD, DATA, GAP} state_t;

  localparam logic [8:0] LP_BIT_LAST = 9'(BIT_CYCLES - 1);
  localparam logic [8:0] LP_BIT_PRE  = 9'(BIT_CYCLES - 2);
  localparam logic [5:0] LP_GAP_LAST = 6'(GAP_BITS - 1);

  state_t      r_state;
  logic [8:0]  r_bitCnt;
  logic [5:0]  r_lineCnt;
  logic [33:0] r_shreg;
  logic        r_udo;
  logic        r_ready;
  logic        r_done;

  logic [33:0] w_load;
  logic        w_parity;
  logic        w_bitEnd;

  assign w_parity = (^tx_data) ^ 1'(PARITY_ODD);
  assign w_bitEnd = (r_bitCnt == LP_BIT_LAST);

  // Bi-phase image of the word: d[15] lands in [33:32], d[0] in [3:2],
  // and the parity pair closes the frame in [1:0].
  always_comb begin
    w_load = '0;
    for (int i = 0; i < 16; i++) begin
      w_load[2*i+3] = tx_data[i];
      w_load[2*i+2] = ~tx_data[i];
    end
    w_load[1] = w_parity;
    w_load[0] = ~w_parity;
  end

  // Frame sequencer. The line register is always loaded with the value of
  // the line bit that starts at this edge, so the output is one cycle behind
  // the decision but exactly aligned with the bit-period boundaries.
  // frame_done is raised one cycle early so that, being registered, it is
  // visible precisely during the last cycle of the gap.
  always_ff @(posedge clock_system or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bitCnt  <= '0;
      r_lineCnt <= '0;
      r_shreg   <= '0;
      r_udo     <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_udo   <= 1'b0;
          r_ready <= 1'b1;
          if (tx_valid && r_ready) begin
            r_shreg   <= w_load;
            r_bitCnt  <= '0;
            r_lineCnt <= '0;
            r_udo     <= 1'b1;
            r_ready   <= 1'b0;
            r_state   <= HEAD;
          end
        end
        HEAD: begin
          if (w_bitEnd) begin
            r_bitCnt <= '0;
            if (r_lineCnt == 6'd2) begin
              r_lineCnt <= '0;
              r_udo     <= r_shreg[33];
              r_state   <= DATA;
            end else begin
              r_lineCnt <= r_lineCnt + 6'd1;
            end
          end else begin
            r_bitCnt <= r_bitCnt + 9'd1;
          end
        end
        DATA: begin
          if (w_bitEnd) begin
            r_bitCnt <= '0;
            r_shreg  <= {r_shreg[32:0], 1'b0};
            if (r_lineCnt == 6'd33) begin
              r_lineCnt <= '0;
              r_udo     <= 1'b0;
              r_state   <= GAP;
            end else begin
              r_lineCnt <= r_lineCnt + 6'd1;
              r_udo     <= r_shreg[32];
            end
          end else begin
            r_bitCnt <= r_bitCnt + 9'd1;
          end
        end
        GAP: begin
          r_udo <= 1'b0;
          if (w_bitEnd) begin
            r_bitCnt <= '0;
            if (r_lineCnt == LP_GAP_LAST) begin
              r_lineCnt <= '0;
              r_ready   <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_lineCnt <= r_lineCnt + 6'd1;
            end
          end else begin
            r_bitCnt <= r_bitCnt + 9'd1;
            if ((r_lineCnt == LP_GAP_LAST) && (r_bitCnt == LP_BIT_PRE)) begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_udo   <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready   = r_ready;
  assign m2_udo     = r_udo;
  assign frame_done = r_done;

endmodule

// File: tb/tb_encode_m2.sv
// tb_encode_m2 : randomized scoreboard bench for encode_m2.
//
// The driver pushes every accepted word (with its accept edge) into a queue;
// an independent monitor watches the line, pops the matching entry when a
// frame starts and compares each cycle of the frame against a line pattern
// built from the frame rules, then decodes the word back from the line.
module tb_encode_m2;

  localparam int BC        = 17;
  localparam int GB        = 3;
  localparam int PO        = 0;
  localparam int FRAME_CYC = (37 + GB) * BC;

  logic        clock_system = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        m2_udo;
  logic        frame_done;

  typedef struct {
    logic [15:0] word;
    int          acceptCyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   framesSent = 0;
  int   framesSeen = 0;
  int   abortCount = 0;
  bit   busy = 1'b0;

  encode_m2 #(
    .BIT_CYCLES (BC),
    .GAP_BITS   (GB),
    .PARITY_ODD (PO)
  ) dut (
    .clock_system (clock_system),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .m2_udo       (m2_udo),
    .frame_done   (frame_done)
  );

  always #5 clock_system = ~clock_system;

  always @(posedge clock_system) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference line value for line bit k of a frame carrying w:
  // 3 sync ones, 16 data pairs {b,~b} MSB first, parity pair, then low gap.
  function automatic logic expLine(input logic [15:0] w, input int k);
    logic b;
    logic p;
    if (k < 3) return 1'b1;
    if (k < 35) begin
      b = w[15 - (k - 3) / 2];
      return (((k - 3) % 2) == 0) ? b : ~b;
    end
    p = logic'((($countones(w) % 2) == 1) ^ (PO != 0));
    if (k == 35) return p;
    if (k == 36) return ~p;
    return 1'b0;
  endfunction

  task automatic applyStimulus(input logic [15:0] w, input bit keep, output int acc);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock_system);
    tx_data  = w;
    tx_valid = 1'b1;
    while (!tx_ready && n < 3 * FRAME_CYC) begin
      @(negedge clock_system);
      n++;
    end
    checkOutput("acceptReady", tx_ready, 1);
    if (!tx_ready) begin
      tx_valid = 1'b0;
      acc = -1;
      return;
    end
    e.word      = w;
    e.acceptCyc = cyc + 1;
    sbq.push_back(e);
    acc = cyc + 1;
    framesSent++;
    @(posedge clock_system);
    #1;
    tx_data = 16'($urandom);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 3 * FRAME_CYC) begin
      @(negedge clock_system);
      n++;
    end
    checkOutput("drainPending", 32'((sbq.size() != 0) || busy), 0);
  endtask

  // Monitor: one pass per frame seen on the line.
  initial begin : monitor
    exp_t        e;
    int          lineErr;
    int          readyErr;
    int          doneErr;
    logic [39:0] samp;
    logic [15:0] dec;
    bit          aborted;
    forever begin
      @(negedge clock_system);
      if (!rst && m2_udo) begin
        checkOutput("framePending", 32'(sbq.size() != 0), 1);
        if (sbq.size() == 0) begin
          while (m2_udo) @(negedge clock_system);
        end else begin
          busy = 1'b1;
          e = sbq.pop_front();
          checkOutput("frameStartCycle", cyc, e.acceptCyc);
          lineErr  = 0;
          readyErr = 0;
          doneErr  = 0;
          samp     = '0;
          aborted  = 1'b0;
          for (int r = 0; r < FRAME_CYC; r++) begin
            if (r > 0) @(negedge clock_system);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            if (m2_udo !== expLine(e.word, r / BC)) lineErr++;
            if (tx_ready !== 1'b0) readyErr++;
            if (frame_done !== (r == FRAME_CYC - 1)) doneErr++;
            if ((r % BC) == BC / 2) samp[r / BC] = m2_udo;
          end
          if (aborted) begin
            abortCount++;
          end else begin
            for (int j = 0; j < 16; j++) dec[15 - j] = samp[3 + 2 * j];
            checkOutput("lineCycleErrors", lineErr, 0);
            checkOutput("readyLowCycleErrors", readyErr, 0);
            checkOutput("frameDoneCycleErrors", doneErr, 0);
            checkOutput("decodedWord", dec, e.word);
            @(negedge clock_system);
            checkOutput("readyAfterGap", tx_ready, 1);
            framesSeen++;
          end
          busy = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    int acc;
    int acc2;
    int bad;
    bit keep;

    // Reset state while reset is held, then quiet idle after release.
    repeat (10) @(negedge clock_system);
    checkOutput("resetUdo", m2_udo, 0);
    checkOutput("resetReady", tx_ready, 1);
    checkOutput("resetDone", frame_done, 0);
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clock_system);
      if (m2_udo !== 1'b0 || tx_ready !== 1'b1 || frame_done !== 1'b0) bad++;
    end
    checkOutput("idleQuietCycles", bad, 0);

    // Directed words: mixed pattern, all ones, all zeros, single MSB.
    applyStimulus(16'hA5C3, 1'b0, acc);
    waitIdle();
    applyStimulus(16'hFFFF, 1'b0, acc);
    applyStimulus(16'h0000, 1'b0, acc);
    applyStimulus(16'h8000, 1'b0, acc);
    waitIdle();

    // Back-to-back with valid held high: exact frame period.
    applyStimulus(16'h1234, 1'b1, acc);
    applyStimulus(16'h8001, 1'b0, acc2);
    checkOutput("backToBackPeriod", acc2 - acc, FRAME_CYC + 1);
    waitIdle();

    // Reset in the middle of line bit 20 (a high data half-bit for 16'h5A0F).
    applyStimulus(16'h5A0F, 1'b0, acc);
    while (cyc < acc + 20 * BC + BC / 2) @(negedge clock_system);
    checkOutput("udoBeforeAbort", m2_udo, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("udoAsyncClear", m2_udo, 0);
    checkOutput("readyInReset", tx_ready, 1);
    bad = 0;
    repeat (3) begin
      @(negedge clock_system);
      if (frame_done !== 1'b0) bad++;
    end
    rst = 1'b0;
    @(negedge clock_system);
    checkOutput("readyAfterAbort", tx_ready, 1);
    repeat (FRAME_CYC) begin
      @(negedge clock_system);
      if (frame_done !== 1'b0 || m2_udo !== 1'b0) bad++;
    end
    checkOutput("quietAfterAbort", bad, 0);
    checkOutput("abortCount", abortCount, 1);
    applyStimulus(16'hC3A5, 1'b0, acc);
    waitIdle();

    // Random words, sometimes back-to-back, sometimes with idle spacing.
    for (int i = 0; i < 40; i++) begin
      keep = (i < 39) && ($urandom_range(0, 3) == 0);
      applyStimulus(16'($urandom), keep, acc);
      if (!keep) repeat ($urandom_range(0, 5)) @(negedge clock_system);
    end
    waitIdle();

    checkOutput("framesSeen", framesSeen, framesSent - 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
